// File: rtl/id_stage_buf_pkg.sv
// Shared decode types for the ID stage: opcode constants, instruction format enum
// and the decoded-entry record stored in the elastic buffer.
package id_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } fmt_e;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        wr_reg_n;
        logic        illegal;
        logic        uses_rs1;
        logic        uses_rs2;
    } dec_t;

    // Value an empty/reset slot presents: no register write, everything else zero.
    function automatic dec_t dec_rst_val();
        dec_t d;
        d          = '0;
        d.wr_reg_n = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/id_stage_buf_if.sv
// IF -> ID -> EX handshake bundle plus the EX-side hazard and flush inputs.
// slave = decode buffer side, master = the driver of IF/EX stimulus.
interface id_stage_buf_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [PC_W-1:0] in_pc;
    logic [31:0]     in_ir;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [31:0]     imm;
    logic            wr_reg_n;
    logic            illegal;
    logic            ex_is_load;
    logic [4:0]      ex_rd;
    logic            flush;

    modport slave (
        input  in_valid, in_pc, in_ir, out_ready, ex_is_load, ex_rd, flush,
        output in_ready, out_valid, out_pc, rs1, rs2, rd, opcode, funct3, funct7,
               imm, wr_reg_n, illegal
    );

    modport master (
        output in_valid, in_pc, in_ir, out_ready, ex_is_load, ex_rd, flush,
        input  in_ready, out_valid, out_pc, rs1, rs2, rd, opcode, funct3, funct7,
               imm, wr_reg_n, illegal
    );
endinterface

// File: rtl/id_stage_buf_decode.sv
// RV32I field decoder: instruction word -> dec_t.
// Latency: purely combinational, 0 cycles.
// Backpressure: none, no state.
module id_decode
    import id_pkg::*;
(
    input  logic [31:0] ir,
    output dec_t        dec
);
    fmt_e fmt;

    always_comb begin
        fmt = FMT_BAD;
        case (ir[6:0])
            OP_LUI, OP_AUIPC:           fmt = FMT_U;
            OP_JAL:                     fmt = FMT_J;
            OP_JALR, OP_LOAD, OP_IMM:   fmt = FMT_I;
            OP_BRANCH:                  fmt = FMT_B;
            OP_STORE:                   fmt = FMT_S;
            OP_OP:                      fmt = FMT_R;
            default:                    fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        dec          = '0;
        dec.opcode   = ir[6:0];
        dec.illegal  = (fmt == FMT_BAD);
        dec.uses_rs1 = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
        dec.uses_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);

        // Fields a format does not carry are forced to zero so downstream compares stay clean.
        if (dec.uses_rs1) begin
            dec.rs1    = ir[19:15];
            dec.funct3 = ir[14:12];
        end
        if (dec.uses_rs2) begin
            dec.rs2 = ir[24:20];
        end
        if ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J)) begin
            dec.rd = ir[11:7];
        end
        if (fmt == FMT_R) begin
            dec.funct7 = ir[31:25];
        end

        case (fmt)
            FMT_I:   dec.imm = {{20{ir[31]}}, ir[31:20]};
            FMT_S:   dec.imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            FMT_B:   dec.imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            FMT_U:   dec.imm = {ir[31:12], 12'b0};
            FMT_J:   dec.imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: dec.imm = 32'd0;
        endcase

        dec.wr_reg_n = (dec.rd == 5'd0);
    end
endmodule

// File: rtl/id_stage_buf.sv
// RV32I decode stage with a DEPTH-entry elastic buffer between IF and EX.
// Latency: an entry pushed in cycle N is at the head in cycle N+1.
// Backpressure: in_ready is registered-only (count < DEPTH); out_valid gated by load-use stall.
module id_stage_buf
    import id_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int PC_W      = 32,
    parameter int HAZARD_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    id_stage_buf_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    dec_t            dec_mem_q [DEPTH];
    dec_t            dec_mem_d [DEPTH];
    logic [PC_W-1:0] pc_mem_q  [DEPTH];
    logic [PC_W-1:0] pc_mem_d  [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    dec_t in_dec;
    dec_t head;
    logic push, pop, stall, not_empty;

    id_decode u_decode (
        .ir  (bus.in_ir),
        .dec (in_dec)
    );

    assign head      = dec_mem_q[rd_ptr_q];
    assign not_empty = (count_q != '0);

    always_comb begin
        stall = 1'b0;
        if (HAZARD_EN != 0) begin
            stall = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                    ((head.uses_rs1 && (head.rs1 == bus.ex_rd)) ||
                     (head.uses_rs2 && (head.rs2 == bus.ex_rd)));
        end
    end

    assign bus.in_ready  = (count_q != FULL_CNT);
    assign bus.out_valid = not_empty && !stall;
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    assign bus.out_pc   = pc_mem_q[rd_ptr_q];
    assign bus.rs1      = head.rs1;
    assign bus.rs2      = head.rs2;
    assign bus.rd       = head.rd;
    assign bus.opcode   = head.opcode;
    assign bus.funct3   = head.funct3;
    assign bus.funct7   = head.funct7;
    assign bus.imm      = head.imm;
    assign bus.wr_reg_n = head.wr_reg_n;
    assign bus.illegal  = head.illegal;

    always_comb begin
        dec_mem_d = dec_mem_q;
        pc_mem_d  = pc_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        // Flush wins over a same-cycle push/pop: the incoming word is dropped.
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                dec_mem_d[wr_ptr_q] = in_dec;
                pc_mem_d[wr_ptr_q]  = bus.in_pc;
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                dec_mem_q[i] <= dec_rst_val();
                pc_mem_q[i]  <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            dec_mem_q <= dec_mem_d;
            pc_mem_q  <= pc_mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end
endmodule

// File: tb/tb_id_stage_buf.sv
// Directed bench for id_stage_buf: decode vectors, fill/wrap ordering, load-use stall,
// flush and mid-operation reset, against a second instance with the interlock disabled.
module tb_id_stage_buf;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_stage_buf_if #(.PC_W(32)) bus_a ();
    id_stage_buf_if #(.PC_W(32)) bus_b ();

    id_stage_buf #(.DEPTH(2), .PC_W(32), .HAZARD_EN(1)) dut (
        .clk (clk), .rst (rst), .bus (bus_a.slave)
    );
    id_stage_buf #(.DEPTH(2), .PC_W(32), .HAZARD_EN(0)) dut_nh (
        .clk (clk), .rst (rst), .bus (bus_b.slave)
    );

    assign bus_b.in_valid   = bus_a.in_valid;
    assign bus_b.in_pc      = bus_a.in_pc;
    assign bus_b.in_ir      = bus_a.in_ir;
    assign bus_b.out_ready  = bus_a.out_ready;
    assign bus_b.ex_is_load = bus_a.ex_is_load;
    assign bus_b.ex_rd      = bus_a.ex_rd;
    assign bus_b.flush      = bus_a.flush;

    typedef struct {
        logic [31:0] ir;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        wrn, ill;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd);
        return {12'd0, 5'd0, 3'b000, rd, 7'b0010011};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            ir            rs1 rs2 rd  opcode f3 f7     imm            wrn ill
        vecs[0]  = '{32'h000001B7, 0,  0,  3,  7'h37, 0, 7'h00, 32'h0000_0000, 0,  0}; // LUI
        vecs[1]  = '{32'h0020006F, 0,  0,  0,  7'h6F, 0, 7'h00, 32'h0000_0002, 1,  0}; // JAL x0
        vecs[2]  = '{32'h00208163, 1,  2,  0,  7'h63, 0, 7'h00, 32'h0000_0002, 1,  0}; // BEQ
        vecs[3]  = '{32'h80108193, 1,  0,  3,  7'h13, 0, 7'h00, 32'hFFFF_F801, 0,  0}; // ADDI
        vecs[4]  = '{32'h0000007F, 0,  0,  0,  7'h7F, 0, 7'h00, 32'h0000_0000, 1,  1}; // bad op
        vecs[5]  = '{32'h002081B3, 1,  2,  3,  7'h33, 0, 7'h00, 32'h0000_0000, 0,  0}; // ADD
        vecs[6]  = '{32'h0020A423, 1,  2,  0,  7'h23, 2, 7'h00, 32'h0000_0008, 1,  0}; // SW
        vecs[7]  = '{32'hFFFFF297, 0,  0,  5,  7'h17, 0, 7'h00, 32'hFFFF_F000, 0,  0}; // AUIPC
        vecs[8]  = '{32'hFFC100E7, 2,  0,  1,  7'h67, 0, 7'h00, 32'hFFFF_FFFC, 0,  0}; // JALR
        vecs[9]  = '{32'h407302B3, 6,  7,  5,  7'h33, 0, 7'h20, 32'h0000_0000, 0,  0}; // SUB
        vecs[10] = '{32'hFFFFFFFF, 0,  0,  0,  7'h7F, 0, 7'h00, 32'h0000_0000, 1,  1}; // bad op

        bus_a.in_valid   = 1'b0;
        bus_a.in_pc      = '0;
        bus_a.in_ir      = '0;
        bus_a.out_ready  = 1'b0;
        bus_a.ex_is_load = 1'b0;
        bus_a.ex_rd      = '0;
        bus_a.flush      = 1'b0;

        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst.out_valid", 32'(bus_a.out_valid), 0);
        chk("rst.in_ready",  32'(bus_a.in_ready),  1);
        chk("rst.rd",        32'(bus_a.rd),        0);
        chk("rst.imm",       bus_a.imm,            0);
        chk("rst.out_pc",    bus_a.out_pc,         0);
        chk("rst.wr_reg_n",  32'(bus_a.wr_reg_n),  1);

        // Decode table: push one word, inspect head next cycle, pop it.
        for (int i = 0; i < NV; i++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_ir    = vecs[i].ir;
            bus_a.in_pc    = 32'h100 + 32'(i * 4);
            tick();
            bus_a.in_valid = 1'b0;
            chk($sformatf("v%0d.out_valid", i), 32'(bus_a.out_valid), 1);
            chk($sformatf("v%0d.out_pc", i),    bus_a.out_pc, 32'h100 + 32'(i * 4));
            chk($sformatf("v%0d.rs1", i),       32'(bus_a.rs1),      32'(vecs[i].rs1));
            chk($sformatf("v%0d.rs2", i),       32'(bus_a.rs2),      32'(vecs[i].rs2));
            chk($sformatf("v%0d.rd", i),        32'(bus_a.rd),       32'(vecs[i].rd));
            chk($sformatf("v%0d.opcode", i),    32'(bus_a.opcode),   32'(vecs[i].opcode));
            chk($sformatf("v%0d.funct3", i),    32'(bus_a.funct3),   32'(vecs[i].f3));
            chk($sformatf("v%0d.funct7", i),    32'(bus_a.funct7),   32'(vecs[i].f7));
            chk($sformatf("v%0d.imm", i),       bus_a.imm,           vecs[i].imm);
            chk($sformatf("v%0d.wr_reg_n", i),  32'(bus_a.wr_reg_n), 32'(vecs[i].wrn));
            chk($sformatf("v%0d.illegal", i),   32'(bus_a.illegal),  32'(vecs[i].ill));
            bus_a.out_ready = 1'b1;
            tick();
            bus_a.out_ready = 1'b0;
            chk($sformatf("v%0d.drained", i), 32'(bus_a.out_valid), 0);
        end

        // Fill with out_ready=0: three offered, two accepted.
        bus_a.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_a.in_ir = addi(5'(10 + i));
            bus_a.in_pc = 32'h200 + 32'(i * 4);
            tick();
            chk($sformatf("fill%0d.in_ready", i), 32'(bus_a.in_ready), (i == 0) ? 1 : 0);
        end
        bus_a.in_valid = 1'b0;
        chk("fill.head_pc", bus_a.out_pc, 32'h200);
        chk("fill.head_rd", 32'(bus_a.rd), 10);
        bus_a.out_ready = 1'b1;
        #1;
        chk("full_pop.in_ready_same_cycle", 32'(bus_a.in_ready), 0);
        tick();
        chk("pop1.head_rd", 32'(bus_a.rd), 11);
        chk("pop1.in_ready", 32'(bus_a.in_ready), 1);
        // Simultaneous push+pop across the pointer wrap.
        bus_a.in_valid = 1'b1;
        bus_a.in_ir    = addi(5'd20);
        bus_a.in_pc    = 32'h300;
        tick();
        chk("pp.out_valid", 32'(bus_a.out_valid), 1);
        chk("pp.head_rd",   32'(bus_a.rd), 20);
        chk("pp.in_ready",  32'(bus_a.in_ready), 1);
        bus_a.out_ready = 1'b0;
        bus_a.in_ir     = addi(5'd21);
        bus_a.in_pc     = 32'h304;
        tick();
        bus_a.in_valid = 1'b0;
        chk("wrap.in_ready", 32'(bus_a.in_ready), 0);
        chk("wrap.head_pc",  bus_a.out_pc, 32'h300);
        bus_a.out_ready = 1'b1;
        tick();
        chk("wrap.second_pc", bus_a.out_pc, 32'h304);
        chk("wrap.second_rd", 32'(bus_a.rd), 21);
        tick();
        bus_a.out_ready = 1'b0;
        chk("wrap.empty", 32'(bus_a.out_valid), 0);

        // Load-use interlock on ADD x3,x1,x2.
        bus_a.in_valid = 1'b1;
        bus_a.in_ir    = 32'h002081B3;
        bus_a.in_pc    = 32'h400;
        tick();
        bus_a.in_valid   = 1'b0;
        bus_a.ex_is_load = 1'b1;
        bus_a.ex_rd      = 5'd2;
        #1;
        chk("haz.rs2_match",     32'(bus_a.out_valid), 0);
        chk("haz.no_interlock",  32'(bus_b.out_valid), 1);
        bus_a.ex_rd = 5'd1;
        #1;
        chk("haz.rs1_match",     32'(bus_a.out_valid), 0);
        bus_a.ex_rd = 5'd0;
        #1;
        chk("haz.rd_zero",       32'(bus_a.out_valid), 1);
        bus_a.ex_rd = 5'd3;
        #1;
        chk("haz.rd_not_src",    32'(bus_a.out_valid), 1);
        bus_a.ex_is_load = 1'b0;
        bus_a.ex_rd      = 5'd2;
        #1;
        chk("haz.not_load",      32'(bus_a.out_valid), 1);
        bus_a.ex_rd     = 5'd0;
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;
        chk("haz.drained", 32'(bus_a.out_valid), 0);

        // LUI x1 does not read x1: no stall even though its rd field matches.
        bus_a.in_valid = 1'b1;
        bus_a.in_ir    = 32'h000000B7;
        tick();
        bus_a.in_valid   = 1'b0;
        bus_a.ex_is_load = 1'b1;
        bus_a.ex_rd      = 5'd1;
        #1;
        chk("haz.lui_no_use", 32'(bus_a.out_valid), 1);
        bus_a.ex_is_load = 1'b0;
        bus_a.ex_rd      = 5'd0;
        bus_a.out_ready  = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;

        // Flush with two buffered entries and a push offered in the same cycle.
        bus_a.in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus_a.in_ir = addi(5'(24 + i));
            bus_a.in_pc = 32'h500 + 32'(i * 4);
            tick();
        end
        bus_a.in_ir = addi(5'd30);
        bus_a.in_pc = 32'h5F0;
        bus_a.flush = 1'b1;
        tick();
        bus_a.flush    = 1'b0;
        bus_a.in_valid = 1'b0;
        chk("flush2.out_valid", 32'(bus_a.out_valid), 0);
        chk("flush2.in_ready",  32'(bus_a.in_ready),  1);
        tick();
        chk("flush2.still_empty", 32'(bus_a.out_valid), 0);
        // Count and pointers restart at zero: exactly two more fit, first in is first out.
        bus_a.in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus_a.in_ir = addi(5'(26 + i));
            bus_a.in_pc = 32'h600 + 32'(i * 4);
            tick();
            chk($sformatf("refill%0d.in_ready", i), 32'(bus_a.in_ready), (i == 0) ? 1 : 0);
        end
        bus_a.in_valid = 1'b0;
        chk("refill.head_pc", bus_a.out_pc, 32'h600);
        bus_a.out_ready = 1'b1;
        tick(); tick();
        bus_a.out_ready = 1'b0;
        chk("refill.drained", 32'(bus_a.out_valid), 0);

        // Flush with one entry while a push is accepted: pushed word never issues.
        bus_a.in_valid = 1'b1;
        bus_a.in_ir    = addi(5'd7);
        tick();
        bus_a.in_ir = addi(5'd8);
        bus_a.flush = 1'b1;
        #1;
        chk("flush1.in_ready_during", 32'(bus_a.in_ready), 1);
        tick();
        bus_a.flush    = 1'b0;
        bus_a.in_valid = 1'b0;
        chk("flush1.out_valid", 32'(bus_a.out_valid), 0);
        tick();
        chk("flush1.no_issue", 32'(bus_a.out_valid), 0);

        // Reset asserted with a live entry.
        bus_a.in_valid = 1'b1;
        bus_a.in_ir    = 32'h002081B3;
        bus_a.in_pc    = 32'h700;
        tick();
        bus_a.in_valid = 1'b0;
        chk("midrst.pre", 32'(bus_a.out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst.out_valid", 32'(bus_a.out_valid), 0);
        chk("midrst.in_ready",  32'(bus_a.in_ready),  1);
        chk("midrst.rd",        32'(bus_a.rd),        0);
        chk("midrst.wr_reg_n",  32'(bus_a.wr_reg_n),  1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
